// File: rtl/windup_scheduler.sv
// windup_scheduler: queues burst lengths and loads them one at a time into windup_clock,
// mirroring the downstream countdown and enforcing an idle gap between bursts.
module windup_scheduler #(
  parameter int BIT   = 16,
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [BIT-1:0]           req_len,
  output logic                     wr_en,
  output logic [BIT-1:0]           wind,
  output logic                     busy,
  output logic [BIT-1:0]           remaining,
  output logic                     burst_done,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [GW-1:0] GLAST = GW'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_GAP} state_t;

  state_t state, nxt;
  logic [BIT-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [GW-1:0] gcnt;
  logic [BIT-1:0] head;
  logic push, pop;

  assign head = mem[rd_ptr];
  assign req_ready = fifo_count != FULL;
  assign push = req_valid && req_ready;
  assign pop = state == S_IDLE && fifo_count != '0;
  assign busy = state != S_IDLE || fifo_count != '0;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: nxt = pop && head != '0 ? S_LOAD : S_IDLE;
      S_LOAD: nxt = S_RUN;
      S_RUN:  nxt = remaining == BIT'(1) ? (GAP == 0 ? S_IDLE : S_GAP) : S_RUN;
      S_GAP:  nxt = gcnt == GLAST ? S_IDLE : S_GAP;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      wr_en      <= 1'b0;
      wind       <= '0;
      remaining  <= '0;
      burst_done <= 1'b0;
      gcnt       <= '0;
    end else begin
      state <= nxt;
      if (push) begin
        mem[wr_ptr] <= req_len;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      wr_en <= nxt == S_LOAD;
      if (nxt == S_LOAD) wind <= head;
      // wind doubles as the latched length for the LOAD -> RUN handoff
      if (state == S_LOAD) remaining <= wind;
      else if (state == S_RUN) remaining <= remaining - BIT'(1);
      burst_done <= (pop && head == '0) || (state == S_RUN && remaining == BIT'(1));
      gcnt <= state == S_GAP ? gcnt + GW'(1) : '0;
    end
  end
endmodule

// File: tb/tb_windup_scheduler.sv
// tb_windup_scheduler: directed checks of windup_scheduler with BIT=16, DEPTH=4, GAP=2.
module tb_windup_scheduler;
  logic clk = 0, rst_n = 0, req_valid = 0, req_ready;
  logic [15:0] req_len = '0, wind, remaining;
  logic wr_en, busy, burst_done;
  logic [2:0] fifo_count;

  int n_pass = 0, n_chk = 0;
  int cyc = 0, dones = 0, run_cyc = 0, bad_excl = 0, bad_consec = 0, bad_full = 0;
  int max_cnt = 0, min_gap = 1000, last_done = -1000;
  bit prev_wr = 0, gap_chk = 0;
  logic [15:0] loads[$];
  int ld_cyc[$], dn_cyc[$];

  windup_scheduler #(.BIT(16), .DEPTH(4), .GAP(2)) dut (
    .clk_in(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_len(req_len), .wr_en(wr_en), .wind(wind), .busy(busy),
    .remaining(remaining), .burst_done(burst_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (wr_en) begin
      loads.push_back(wind);
      ld_cyc.push_back(cyc);
      if (burst_done) bad_excl++;
      if (prev_wr) bad_consec++;
      if (gap_chk && cyc - last_done < min_gap) min_gap = cyc - last_done;
    end
    if (burst_done) begin
      dones++;
      dn_cyc.push_back(cyc);
      last_done = cyc;
    end
    if (remaining != 0) run_cyc++;
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    if (fifo_count == 3'd4 && req_ready) bad_full++;
    prev_wr = wr_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] l);
    bit acc;
    int n = 0;
    req_valid = 1;
    req_len = l;
    do begin
      acc = req_ready;
      tick(1);
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int n = 0;
    while (busy && n < lim) begin
      tick(1);
      n++;
    end
    check(tag, busy, 0);
  endtask

  initial begin
    int b_ld, b_dn, b_run;
    tick(2);
    check("rst_wr_en", wr_en, 0);
    check("rst_wind", wind, 0);
    check("rst_remaining", remaining, 0);
    check("rst_done", burst_done, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", req_ready, 1);
    rst_n = 1;
    tick(1);
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", req_ready, 1);

    send(16'd3);
    req_valid = 0;
    check("t2_count", fifo_count, 1);
    check("t2_busy", busy, 1);
    check("t2_wr_early", wr_en, 0);
    tick(1);
    check("t2_wr_en", wr_en, 1);
    check("t2_wind", wind, 3);
    tick(1);
    check("t2_wr_once", wr_en, 0);
    check("t2_rem3", remaining, 3);
    tick(1);
    check("t2_rem2", remaining, 2);
    tick(1);
    check("t2_rem1", remaining, 1);
    check("t2_no_done", burst_done, 0);
    tick(1);
    check("t2_rem0", remaining, 0);
    check("t2_done", burst_done, 1);
    check("t2_busy_gap", busy, 1);
    tick(1);
    check("t2_done_once", burst_done, 0);
    check("t2_busy_gap2", busy, 1);
    tick(1);
    check("t2_idle", busy, 0);
    check("t2_wind_hold", wind, 3);

    b_ld = loads.size();
    b_dn = dones;
    gap_chk = 1;
    for (int i = 1; i <= 6; i++) send(16'(i));
    req_valid = 0;
    wait_idle("t3_idle", 300);
    gap_chk = 0;
    check("t3_max_count", max_cnt, 4);
    check("t3_full_ready", bad_full, 0);
    check("t3_loads", loads.size() - b_ld, 6);
    for (int i = 0; i < 6 && b_ld + i < loads.size(); i++)
      check($sformatf("t3_order%0d", i), loads[b_ld+i], i + 1);
    check("t3_dones", dones - b_dn, 6);
    check("t3_gap", min_gap >= 3, 1);

    b_ld = loads.size();
    b_dn = dn_cyc.size();
    send(16'd2);
    send(16'd0);
    send(16'd2);
    req_valid = 0;
    wait_idle("t4_idle", 100);
    check("t4_loads", loads.size() - b_ld, 2);
    check("t4_dones", dn_cyc.size() - b_dn, 3);
    if (loads.size() - b_ld == 2 && dn_cyc.size() - b_dn == 3) begin
      check("t4_len_a", loads[b_ld], 2);
      check("t4_len_b", loads[b_ld+1], 2);
      check("t4_zero_after_first", dn_cyc[b_dn+1] > dn_cyc[b_dn], 1);
      check("t4_zero_before_second", dn_cyc[b_dn+1] < ld_cyc[b_ld+1], 1);
    end

    b_ld = loads.size();
    b_dn = dones;
    b_run = run_cyc;
    send(16'hFFFF);
    req_valid = 0;
    wait_idle("t5_idle", 70000);
    check("t5_run_cycles", run_cyc - b_run, 65535);
    check("t5_dones", dones - b_dn, 1);
    check("t5_loads", loads.size() - b_ld, 1);
    check("t5_rem_end", remaining, 0);

    send(16'd8);
    send(16'd1);
    send(16'd1);
    req_valid = 0;
    begin
      int n = 0;
      while (remaining != 16'd5 && n < 50) begin
        tick(1);
        n++;
      end
    end
    check("t6_rem5", remaining, 5);
    check("t6_queued", fifo_count, 2);
    rst_n = 0;
    tick(1);
    check("t6_count", fifo_count, 0);
    check("t6_rem", remaining, 0);
    check("t6_busy", busy, 0);
    check("t6_wind", wind, 0);
    rst_n = 1;
    b_ld = loads.size();
    b_dn = dones;
    tick(20);
    check("t6_no_wr", loads.size() - b_ld, 0);
    check("t6_no_done", dones - b_dn, 0);
    check("t6_ready", req_ready, 1);

    check("excl_wr_done", bad_excl, 0);
    check("wr_single_cycle", bad_consec, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
